// File: rtl/axi_pkg.sv
// Shared AXI read-side widths, response/burst encodings and the responder state type.
// The GAP state is only reachable when AXI_RESP_DECERR_EN is defined.
package axi_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        LOAD = 3'd2,
        RESP = 3'd3,
        GAP  = 3'd4
    } rresp_fsm_e;

    // Anything other than FIXED (including WRAP and the reserved code) walks upward.
    function automatic logic burst_is_incr(input logic [1:0] burst);
        return (burst != BURST_FIXED);
    endfunction

endpackage

// File: rtl/axi_rd_burst_ctr.sv
// Beat counter, SRAM word-address stepper and last-beat flag for one read burst.
module axi_rd_burst_ctr
    import axi_pkg::*;
#(
    parameter int MEM_AW = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [MEM_AW-1:0]       start_addr,
    input  logic [AXI_LEN_BITS-1:0] len,
    input  logic                    incr,
    input  logic                    step,
    output logic [MEM_AW-1:0]       addr,
    output logic                    last
);

    localparam logic [AXI_LEN_BITS-1:0] LEN_ONE  = {{(AXI_LEN_BITS-1){1'b0}}, 1'b1};
    localparam logic [MEM_AW-1:0]       ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

    logic [AXI_LEN_BITS-1:0] cnt_r;
    logic [MEM_AW-1:0]       addr_r;
    logic                    incr_r;

    // Burst bookkeeping: load on AR accept, advance on each non-final beat handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {AXI_LEN_BITS{1'b0}};
            addr_r <= {MEM_AW{1'b0}};
            incr_r <= 1'b0;
        end else if (load) begin
            cnt_r  <= len;
            addr_r <= start_addr;
            incr_r <= incr;
        end else if (step) begin
            cnt_r <= cnt_r - LEN_ONE;
            if (incr_r) begin
                addr_r <= addr_r + ADDR_ONE;
            end
        end
    end

    assign addr = addr_r;
    assign last = (cnt_r == {AXI_LEN_BITS{1'b0}});

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 slave read responder over a synchronous single-port word SRAM, one burst at a time.
// Optional macro AXI_RESP_DECERR_EN: out-of-window bursts answer DECERR without touching the SRAM.
module axi_read_responder
    import axi_pkg::*;
#(
    parameter int                       MEM_AW    = 14,
    parameter logic [AXI_ADDR_BITS-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_IDS_BITS-1:0]  ARID_S,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_S,
    input  logic [2:0]               ARSIZE_S,
    input  logic [1:0]               ARBURST_S,
    input  logic                     ARVALID_S,
    output logic                     ARREADY_S,
    output logic [AXI_IDS_BITS-1:0]  RID_S,
    output logic [AXI_DATA_BITS-1:0] RDATA_S,
    output logic [1:0]               RRESP_S,
    output logic                     RLAST_S,
    output logic                     RVALID_S,
    input  logic                     RREADY_S,
    output logic                     mem_cs,
    output logic [MEM_AW-1:0]        mem_addr,
    input  logic [AXI_DATA_BITS-1:0] mem_dout
);

    rresp_fsm_e state_r, state_n;

    logic                     arready_r, rvalid_r, mem_cs_r, rlast_r;
    logic [AXI_IDS_BITS-1:0]  id_r, rid_r;
    logic [AXI_DATA_BITS-1:0] rdata_r;
    logic [1:0]               rresp_r;
    logic                     ar_hs_s, r_hs_s, last_s, ctr_load_s, ctr_step_s;
    logic                     ar_skip_s, beat_skip_s;
    logic [AXI_ADDR_BITS-1:0] offset_s;
    logic [MEM_AW-1:0]        ctr_addr_s;
    logic                     unused_s;

    assign ar_hs_s  = ARVALID_S & arready_r;
    assign r_hs_s   = rvalid_r & RREADY_S;
    assign offset_s = ARADDR_S - BASE_ADDR;
    assign unused_s = ^{ARSIZE_S, offset_s[1:0], offset_s[AXI_ADDR_BITS-1:MEM_AW+2]};

`ifdef AXI_RESP_DECERR_EN
    localparam logic [AXI_ADDR_BITS:0] WINDOW_BYTES = 33'd1 << (MEM_AW + 2);

    logic decerr_r;
    assign ar_skip_s   = (ARADDR_S < BASE_ADDR) || ({1'b0, offset_s} >= WINDOW_BYTES);
    assign beat_skip_s = decerr_r;
`else
    assign ar_skip_s   = 1'b0;
    assign beat_skip_s = 1'b0;
`endif

    axi_rd_burst_ctr #(.MEM_AW(MEM_AW)) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (ctr_load_s),
        .start_addr (offset_s[MEM_AW+1:2]),
        .len        (ARLEN_S),
        .incr       (burst_is_incr(ARBURST_S)),
        .step       (ctr_step_s),
        .addr       (ctr_addr_s),
        .last       (last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode and counter control.
    always_comb begin
        state_n    = state_r;
        ctr_load_s = 1'b0;
        ctr_step_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ar_hs_s) begin
                    ctr_load_s = 1'b1;
                    state_n    = ar_skip_s ? GAP : READ;
                end else begin
                    state_n = IDLE;
                end
            end
            READ: state_n = LOAD;
            LOAD: state_n = RESP;
            RESP: begin
                if (r_hs_s && rlast_r) begin
                    state_n = IDLE;
                end else if (r_hs_s) begin
                    ctr_step_s = 1'b1;
                    state_n    = beat_skip_s ? GAP : READ;
                end else begin
                    state_n = RESP;
                end
            end
            GAP:     state_n = RESP;
            default: state_n = IDLE;
        endcase
    end

    // Per-burst request attributes captured at AR accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_r <= {AXI_IDS_BITS{1'b0}};
`ifdef AXI_RESP_DECERR_EN
            decerr_r <= 1'b0;
`endif
        end else if (ar_hs_s) begin
            id_r <= ARID_S;
`ifdef AXI_RESP_DECERR_EN
            decerr_r <= ar_skip_s;
`endif
        end
    end

    // Registered handshake/strobe outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            mem_cs_r  <= 1'b0;
        end else begin
            arready_r <= (state_n == IDLE);
            rvalid_r  <= (state_n == RESP);
            mem_cs_r  <= (state_n == READ);
        end
    end

    // R payload: loaded on entry to RESP, frozen while waiting, zeroed otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rid_r   <= {AXI_IDS_BITS{1'b0}};
            rdata_r <= {AXI_DATA_BITS{1'b0}};
            rresp_r <= RESP_OKAY;
            rlast_r <= 1'b0;
        end else if ((state_n == RESP) && (state_r != RESP)) begin
            rid_r   <= id_r;
            rdata_r <= beat_skip_s ? {AXI_DATA_BITS{1'b0}} : mem_dout;
            rresp_r <= beat_skip_s ? RESP_DECERR : RESP_OKAY;
            rlast_r <= last_s;
        end else if (state_n != RESP) begin
            rid_r   <= {AXI_IDS_BITS{1'b0}};
            rdata_r <= {AXI_DATA_BITS{1'b0}};
            rresp_r <= RESP_OKAY;
            rlast_r <= 1'b0;
        end
    end

    assign ARREADY_S = arready_r;
    assign RVALID_S  = rvalid_r;
    assign RID_S     = rid_r;
    assign RDATA_S   = rdata_r;
    assign RRESP_S   = rresp_r;
    assign RLAST_S   = rlast_r;
    assign mem_cs    = mem_cs_r;
    assign mem_addr  = ctr_addr_s;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder with a behavioural synchronous SRAM.
// Covers the AXI_RESP_DECERR_EN build when that macro is defined, aliasing otherwise.
module tb_axi_read_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S;
    logic        RVALID_S;
    logic        RREADY_S;
    logic        mem_cs;
    logic [13:0] mem_addr;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:16383];
    int          cs_cnt = 0;
    logic [13:0] addr_log [$];
    int          n_vec = 0;
    int          n_err = 0;

    axi_read_responder dut (
        .clk(clk), .rst(rst),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: data appears the cycle after the strobe; every strobe is logged.
    always @(posedge clk) begin
        if (mem_cs) begin
            mem_dout <= mem[mem_addr];
            cs_cnt   <= cs_cnt + 1;
            addr_log.push_back(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARBURST_S = burst;
        ARSIZE_S = 3'b010; ARVALID_S = 1'b1;
        tick();
        ARVALID_S = 1'b0;
    endtask

    task automatic wait_rvalid(input string tag);
        int n = 0;
        while (RVALID_S !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, RVALID_S}, 32'd1);
    endtask

    // Waits for a beat, checks its payload, then lets it handshake (RREADY_S must be 1).
    task automatic take_beat(input string tag, input logic [7:0] id, input logic [31:0] data,
                             input logic last, input logic [1:0] resp);
        wait_rvalid({tag, "_valid"});
        chk({tag, "_data"}, RDATA_S, data);
        chk({tag, "_id"},   {24'd0, RID_S}, {24'd0, id});
        chk({tag, "_last"}, {31'd0, RLAST_S}, {31'd0, last});
        chk({tag, "_resp"}, {30'd0, RRESP_S}, {30'd0, resp});
        tick();
    endtask

    initial begin
        int cs0;
        int lb;
        rst = 1'b1; ARID_S = 8'h00; ARADDR_S = 32'h0; ARLEN_S = 4'h0; ARSIZE_S = 3'b010;
        ARBURST_S = 2'b01; ARVALID_S = 1'b0; RREADY_S = 1'b0;
        mem[16] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) mem[64 + i] = 32'(i + 1);
        mem[2]     = 32'hA5A5_0002;
        mem[16383] = 32'h1111_FFFF;
        mem[0]     = 32'h0000_0F00;

        // Reset state
        tick(); tick();
        chk("rst_arready", {31'd0, ARREADY_S}, 32'd1);
        chk("rst_rvalid",  {31'd0, RVALID_S},  32'd0);
        chk("rst_memcs",   {31'd0, mem_cs},    32'd0);
        chk("rst_rdata",   RDATA_S, 32'd0);
        rst = 1'b0;
        tick();

        // Single beat with exact latency
        RREADY_S = 1'b1;
        send_ar(8'h13, 32'h0000_0040, 4'd0, 2'b01);
        chk("t1_arready_busy", {31'd0, ARREADY_S}, 32'd0);
        chk("t1_memcs",   {31'd0, mem_cs}, 32'd1);
        chk("t1_memaddr", {18'd0, mem_addr}, 32'd16);
        tick();
        chk("t1_rvalid_n2", {31'd0, RVALID_S}, 32'd0);
        chk("t1_rid_idle",  {24'd0, RID_S}, 32'd0);
        tick();
        chk("t1_rvalid_n3", {31'd0, RVALID_S}, 32'd1);
        take_beat("t1", 8'h13, 32'hDEAD_BEEF, 1'b1, 2'b00);
        chk("t1_arready_back", {31'd0, ARREADY_S}, 32'd1);
        chk("t1_rvalid_done",  {31'd0, RVALID_S}, 32'd0);
        chk("t1_rdata_zero",   RDATA_S, 32'd0);

        // INCR burst of four
        cs0 = cs_cnt; lb = addr_log.size();
        send_ar(8'h21, 32'h0000_0100, 4'd3, 2'b01);
        for (int b = 1; b <= 4; b++) take_beat("t2", 8'h21, 32'(b), (b == 4), 2'b00);
        chk("t2_cs_count", 32'(cs_cnt - cs0), 32'd4);
        for (int b = 0; b < 4; b++) chk("t2_addr", {18'd0, addr_log[lb + b]}, 32'(64 + b));

        // Back-pressure on beat 2
        cs0 = cs_cnt;
        send_ar(8'h22, 32'h0000_0100, 4'd3, 2'b01);
        take_beat("t3_b1", 8'h22, 32'd1, 1'b0, 2'b00);
        RREADY_S = 1'b0;
        wait_rvalid("t3_b2_valid");
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", {31'd0, RVALID_S}, 32'd1);
            chk("t3_hold_data",  RDATA_S, 32'd2);
            chk("t3_hold_id",    {24'd0, RID_S}, 32'h22);
            tick();
        end
        chk("t3_hold_cs", 32'(cs_cnt - cs0), 32'd2);
        RREADY_S = 1'b1;
        take_beat("t3_b2", 8'h22, 32'd2, 1'b0, 2'b00);
        take_beat("t3_b3", 8'h22, 32'd3, 1'b0, 2'b00);
        take_beat("t3_b4", 8'h22, 32'd4, 1'b1, 2'b00);
        chk("t3_cs_count", 32'(cs_cnt - cs0), 32'd4);

        // FIXED burst
        lb = addr_log.size();
        send_ar(8'h30, 32'h0000_0008, 4'd2, 2'b00);
        for (int b = 0; b < 3; b++) take_beat("t4", 8'h30, 32'hA5A5_0002, (b == 2), 2'b00);
        for (int b = 0; b < 3; b++) chk("t4_addr", {18'd0, addr_log[lb + b]}, 32'd2);

        // Word-address wrap at the top of the SRAM
        lb = addr_log.size();
        send_ar(8'h40, 32'h0000_FFFC, 4'd1, 2'b01);
        take_beat("t5_b1", 8'h40, 32'h1111_FFFF, 1'b0, 2'b00);
        take_beat("t5_b2", 8'h40, 32'h0000_0F00, 1'b1, 2'b00);
        chk("t5_addr_wrap", {18'd0, addr_log[lb + 1]}, 32'd0);

        // Reset while a beat is waiting
        RREADY_S = 1'b0;
        send_ar(8'h44, 32'h0000_0100, 4'd3, 2'b01);
        wait_rvalid("t6_valid");
        rst = 1'b1;
        tick();
        chk("t6_rst_rvalid",  {31'd0, RVALID_S}, 32'd0);
        chk("t6_rst_arready", {31'd0, ARREADY_S}, 32'd1);
        chk("t6_rst_rdata",   RDATA_S, 32'd0);
        rst = 1'b0;
        cs0 = cs_cnt;
        repeat (4) tick();
        chk("t6_abandon_cs",     32'(cs_cnt - cs0), 32'd0);
        chk("t6_abandon_rvalid", {31'd0, RVALID_S}, 32'd0);
        RREADY_S = 1'b1;
        send_ar(8'h55, 32'h0000_0040, 4'd0, 2'b01);
        take_beat("t6_new", 8'h55, 32'hDEAD_BEEF, 1'b1, 2'b00);

`ifdef AXI_RESP_DECERR_EN
        // Out-of-window burst answers DECERR without SRAM access
        cs0 = cs_cnt;
        send_ar(8'h66, 32'h0001_0000, 4'd1, 2'b01);
        take_beat("t7_b1", 8'h66, 32'd0, 1'b0, 2'b11);
        take_beat("t7_b2", 8'h66, 32'd0, 1'b1, 2'b11);
        chk("t7_no_cs", 32'(cs_cnt - cs0), 32'd0);
`else
        // Out-of-window address aliases into the SRAM; low address bits ignored
        send_ar(8'h66, 32'h0001_0042, 4'd0, 2'b01);
        take_beat("t7_alias", 8'h66, 32'hDEAD_BEEF, 1'b1, 2'b00);
`endif
        chk("end_arready", {31'd0, ARREADY_S}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
